// File: rtl/sdram_burst_arbiter_pkg.sv
// Shared encodings for the SDRAM burst arbiter: command opcodes seen by the
// command unit and the arbiter's state names.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_REF = 2'd1,
    OP_RD  = 2'd2,
    OP_WR  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// Request/command/ack bundle between the FIFO level logic, the arbiter and
// the SDRAM command unit.
//
// Command handshake: the arbiter raises cmd_valid with cmd_op/cmd_addr/cmd_len
// and holds all of them stable until the edge where cmd_valid & cmd_ready are
// both high; that edge is the transfer. cmd_valid never drops before the
// transfer. Afterwards the command unit pulses cmd_done for one cycle when the
// burst completes; cmd_done is only meaningful after an accepted command.
interface sdram_burst_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int LEN_W  = 8
) ();

  logic              ref_req;
  logic              rd_req;
  logic              wr_req;
  logic              rd_sync;
  logic              wr_sync;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_done;
  logic              rd_ack;
  logic              wr_ack;
  logic              busy;

  // Arbiter side
  modport master (
    input  ref_req, rd_req, wr_req, rd_sync, wr_sync, cmd_ready, cmd_done,
    output cmd_valid, cmd_op, cmd_addr, cmd_len, rd_ack, wr_ack, busy
  );

  // Requesters and command unit side
  modport slave (
    output ref_req, rd_req, wr_req, rd_sync, wr_sync, cmd_ready, cmd_done,
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, rd_ack, wr_ack, busy
  );

endinterface

// File: rtl/sdram_burst_arbiter_addr_wrap_ctr.sv
// Burst start-address counter that steps by STEP and wraps back to BASE when
// the next address would reach MAX. A load (sync pulse) beats an increment on
// the same edge.
module addr_wrap_ctr #(
  parameter int ADDR_W = 23,
  parameter int BASE   = 0,
  parameter int MAX    = 1843200,
  parameter int STEP   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  output logic [ADDR_W-1:0] addr
);

  // One extra bit so addr + STEP cannot overflow before the wrap compare.
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [AW1-1:0]    MAX_X  = AW1'(MAX);
  localparam logic [AW1-1:0]    STEP_X = AW1'(STEP);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [AW1-1:0]    next_w;

  // Next address: reload, wrap-aware advance, or hold.
  always_comb begin
    next_w = {1'b0, addr_q} + STEP_X;
    addr_d = addr_q;
    if (load) begin
      addr_d = BASE_A;
    end else if (inc) begin
      addr_d = (next_w >= MAX_X) ? BASE_A : next_w[ADDR_W-1:0];
    end
  end

  // Address register.
  always_ff @(posedge clk) begin
    if (rst) addr_q <= BASE_A;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Schedules refresh, VGA read-prefetch and scanner write bursts onto the SDRAM
// command unit. Priority is REF > RD > WR, except that a pending write wins
// over a read once STARVE_MAX reads have been granted in its face.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int LEN_W       = 8,
  parameter int BURST_LEN   = 32,
  parameter int WR_BASE     = 0,
  parameter int WR_MAX_ADDR = 1843200,
  parameter int RD_BASE     = 0,
  parameter int RD_MAX_ADDR = 1843200,
  parameter int STARVE_MAX  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sdram_burst_arbiter_if.master bus,
  output arb_state_e            dbg_state_o
);

  localparam logic [LEN_W-1:0] LEN_BURST  = LEN_W'(BURST_LEN);
  localparam int               SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rd_ack_q, rd_ack_d;
  logic              wr_ack_q, wr_ack_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_inc;
  logic              wr_inc;
  logic              wr_wins;

  addr_wrap_ctr #(
    .ADDR_W (ADDR_W),
    .BASE   (RD_BASE),
    .MAX    (RD_MAX_ADDR),
    .STEP   (BURST_LEN)
  ) u_rd_ctr (
    .clk  (CLK),
    .rst  (RESET),
    .inc  (rd_inc),
    .load (bus.rd_sync),
    .addr (rd_addr)
  );

  addr_wrap_ctr #(
    .ADDR_W (ADDR_W),
    .BASE   (WR_BASE),
    .MAX    (WR_MAX_ADDR),
    .STEP   (BURST_LEN)
  ) u_wr_ctr (
    .clk  (CLK),
    .rst  (RESET),
    .inc  (wr_inc),
    .load (bus.wr_sync),
    .addr (wr_addr)
  );

  // Arbitration, command capture and completion handling.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    len_d    = len_q;
    starve_d = starve_q;
    rd_ack_d = 1'b0;
    wr_ack_d = 1'b0;
    rd_inc   = 1'b0;
    wr_inc   = 1'b0;
    // A starved write only overrides reads; refresh is never delayed.
    wr_wins  = bus.wr_req && (starve_q == STARVE_LIM);

    unique case (state_q)
      IDLE: begin
        if (bus.ref_req) begin
          op_d    = OP_REF;
          addr_d  = '0;
          len_d   = '0;
          state_d = ISSUE;
        end else if (bus.rd_req && !wr_wins) begin
          op_d    = OP_RD;
          addr_d  = rd_addr;
          len_d   = LEN_BURST;
          state_d = ISSUE;
          if (bus.wr_req && (starve_q != STARVE_LIM)) starve_d = starve_q + SW'(1);
        end else if (bus.wr_req) begin
          op_d     = OP_WR;
          addr_d   = wr_addr;
          len_d    = LEN_BURST;
          state_d  = ISSUE;
          starve_d = '0;
        end
      end
      ISSUE: begin
        // cmd_valid is high throughout ISSUE, so ready alone completes the transfer.
        if (bus.cmd_ready) state_d = BUSY;
      end
      BUSY: begin
        if (bus.cmd_done) begin
          state_d = IDLE;
          unique case (op_q)
            OP_RD: begin
              rd_ack_d = 1'b1;
              rd_inc   = 1'b1;
            end
            OP_WR: begin
              wr_ack_d = 1'b1;
              wr_inc   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      op_q     <= OP_NOP;
      addr_q   <= '0;
      len_q    <= '0;
      starve_q <= '0;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      starve_q <= starve_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign bus.cmd_valid = (state_q == ISSUE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.cmd_op    = op_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_len   = len_q;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.wr_ack    = wr_ack_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Bench for sdram_burst_arbiter: directed scenarios followed by randomized
// transactions; expected commands and acks come from a transaction-level model
// and are checked by an independent monitor.
module tb_sdram_burst_arbiter;

  localparam int ADDR_W     = 23;
  localparam int LEN_W      = 8;
  localparam int BURST      = 32;
  localparam int WR_BASE    = 0;
  localparam int WR_MAX     = 96;
  localparam int RD_BASE    = 0;
  localparam int RD_MAX     = 128;
  localparam int STARVE_MAX = 4;
  localparam int CW         = 1 + 2 + ADDR_W + LEN_W;

  localparam logic [1:0] OP_REF = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_WR  = 2'd3;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   cyc   = 0;
  sdram_arb_pkg::arb_state_e dbg_state;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sdram_burst_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  sdram_burst_arbiter #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .BURST_LEN   (BURST),
    .WR_BASE     (WR_BASE),
    .WR_MAX_ADDR (WR_MAX),
    .RD_BASE     (RD_BASE),
    .RD_MAX_ADDR (RD_MAX),
    .STARVE_MAX  (STARVE_MAX)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] exp_q[$];      // {addr_valid, op, addr, len}
  logic [33:0]   ack_q[$];      // {cycle, rd_ack, wr_ack}
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: burst address pointers and starvation count.
  int m_rd_addr = RD_BASE;
  int m_wr_addr = WR_BASE;
  int m_starve  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int adv(input int a, input int mx, input int base);
    int n;
    n = a + BURST;
    return (n >= mx) ? base : n;
  endfunction

  task automatic model_grant(input logic r, input logic d, input logic w,
                             output logic [1:0] op, output int addr, output int len);
    if (r) begin
      op = OP_REF; addr = 0; len = 0;
    end else if (d && !(w && m_starve == STARVE_MAX)) begin
      op = OP_RD; addr = m_rd_addr; len = BURST;
      if (w && m_starve < STARVE_MAX) m_starve++;
    end else begin
      op = OP_WR; addr = m_wr_addr; len = BURST;
      m_starve = 0;
    end
  endtask

  task automatic model_done(input logic [1:0] op, input logic rs, input logic ws);
    if (rs)              m_rd_addr = RD_BASE;
    else if (op == OP_RD) m_rd_addr = adv(m_rd_addr, RD_MAX, RD_BASE);
    if (ws)              m_wr_addr = WR_BASE;
    else if (op == OP_WR) m_wr_addr = adv(m_wr_addr, WR_MAX, WR_BASE);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, bus.cmd_valid, 0);
    chk({tag, "_op"},    bus.cmd_op, 0);
    chk({tag, "_addr"},  bus.cmd_addr, 0);
    chk({tag, "_len"},   bus.cmd_len, 0);
    chk({tag, "_rdack"}, bus.rd_ack, 0);
    chk({tag, "_wrack"}, bus.wr_ack, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_state"}, dbg_state, sdram_arb_pkg::IDLE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n, input logic rs, input logic ws);
    @(negedge CLK);
    bus.cmd_done = 1'b0; bus.cmd_ready = 1'b0;
    bus.ref_req = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    bus.rd_sync = rs; bus.wr_sync = ws;
    model_done(OP_REF, rs, ws);
    for (int i = 1; i < n; i++) begin
      @(negedge CLK);
      bus.rd_sync = 1'b0; bus.wr_sync = 1'b0;
    end
  endtask

  // One full command: levels applied in IDLE, optional ready stall with
  // request toggling and sync in ISSUE, then cmd_done (or reset) after done_dly.
  task automatic run_cmd(input logic lr, input logic ld, input logic lw,
                         input int wait_rdy, input int done_dly,
                         input logic rs_iss, input logic ws_iss,
                         input logic rs_done, input logic ws_done, input logic abort);
    logic [1:0] e_op;
    int e_addr, e_len;
    logic care;
    @(negedge CLK);
    bus.cmd_done = 1'b0; bus.rd_sync = 1'b0; bus.wr_sync = 1'b0; bus.cmd_ready = 1'b0;
    bus.ref_req = lr; bus.rd_req = ld; bus.wr_req = lw;
    chk("idle_valid", bus.cmd_valid, 0);
    model_grant(lr, ld, lw, e_op, e_addr, e_len);
    care = (e_op != OP_REF);
    exp_q.push_back({care, e_op, ADDR_W'(e_addr), LEN_W'(e_len)});
    @(negedge CLK);
    chk("valid_lat", bus.cmd_valid, 1);
    for (int i = 0; i < wait_rdy; i++) begin
      bus.ref_req = 1'($urandom); bus.rd_req = 1'($urandom); bus.wr_req = 1'($urandom);
      chk("hold_valid", bus.cmd_valid, 1);
      chk("hold_op", bus.cmd_op, e_op);
      if (care) chk("hold_addr", bus.cmd_addr, ADDR_W'(e_addr));
      chk("hold_len", bus.cmd_len, LEN_W'(e_len));
      if (i == 0 && rs_iss) begin bus.rd_sync = 1'b1; m_rd_addr = RD_BASE; end
      if (i == 0 && ws_iss) begin bus.wr_sync = 1'b1; m_wr_addr = WR_BASE; end
      @(negedge CLK);
      bus.rd_sync = 1'b0; bus.wr_sync = 1'b0;
    end
    bus.cmd_ready = 1'b1;
    @(negedge CLK);
    bus.cmd_ready = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("valid_after_accept", bus.cmd_valid, 0);
    for (int i = 1; i < done_dly; i++) begin
      bus.ref_req = 1'($urandom); bus.rd_req = 1'($urandom); bus.wr_req = 1'($urandom);
      @(negedge CLK);
    end
    if (abort) begin
      RESET = 1'b1; bus.cmd_done = 1'b1;
      @(negedge CLK);
      check_reset("abort");
      RESET = 1'b0; bus.cmd_done = 1'b0;
      bus.ref_req = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      m_rd_addr = RD_BASE; m_wr_addr = WR_BASE; m_starve = 0;
    end else begin
      bus.cmd_done = 1'b1; bus.rd_sync = rs_done; bus.wr_sync = ws_done;
      if (e_op == OP_RD) ack_q.push_back({32'(cyc + 1), 2'b10});
      if (e_op == OP_WR) ack_q.push_back({32'(cyc + 1), 2'b01});
      model_done(e_op, rs_done, ws_done);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [CW-1:0] e;
    logic [33:0]   a;
    forever begin
      @(negedge CLK);
      #2;
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (exp_q.size() == 0) chk("cmd_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("cmd_op", bus.cmd_op, e[CW-2 -: 2]);
          if (e[CW-1]) chk("cmd_addr", bus.cmd_addr, e[ADDR_W+LEN_W-1 -: ADDR_W]);
          chk("cmd_len", bus.cmd_len, e[LEN_W-1:0]);
        end
      end
      if (bus.rd_ack || bus.wr_ack) begin
        if (ack_q.size() == 0) chk("ack_unexpected", {bus.rd_ack, bus.wr_ack}, 0);
        else begin
          a = ack_q.pop_front();
          chk("ack_kind", {bus.rd_ack, bus.wr_ack}, a[1:0]);
          chk("ack_cycle", cyc, a[33:2]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic lr, ld, lw;
    bus.ref_req = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    bus.rd_sync = 1'b0; bus.wr_sync = 1'b0;
    bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0;

    // Reset with stray done pulses: no ack, outputs at reset values.
    repeat (2) @(negedge CLK);
    bus.cmd_done = 1'b1;
    @(negedge CLK);
    check_reset("reset");
    RESET = 1'b0; bus.cmd_done = 1'b0;

    // Write-only, zero-wait accept, done 4 cycles later: 0, 32, 64 then wrap to 0.
    for (int i = 0; i < 4; i++) run_cmd(0, 0, 1, 0, 4, 0, 0, 0, 0, 0);
    idle(2, 0, 0);

    // cmd_done while idle must be ignored.
    @(negedge CLK); bus.cmd_done = 1'b1;
    @(negedge CLK); bus.cmd_done = 1'b0;

    // All requests: REF, then four RDs, then starved WR, then RD again.
    run_cmd(1, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) run_cmd(0, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    idle(2, 1, 0);

    // Read at 64 finishing together with rd_sync: next read back at 0.
    run_cmd(0, 1, 0, 0, 3, 0, 0, 0, 0, 0);
    run_cmd(0, 1, 0, 0, 3, 0, 0, 0, 0, 0);
    run_cmd(0, 1, 0, 1, 3, 0, 0, 1, 0, 0);
    run_cmd(0, 1, 0, 0, 3, 0, 0, 0, 0, 0);

    // Ready held low 10 cycles with rd_req toggling and rd_sync in ISSUE.
    run_cmd(0, 1, 0, 10, 3, 1, 0, 0, 0, 0);
    run_cmd(0, 1, 0, 0, 2, 0, 0, 0, 0, 0);

    // Reset in the middle of a write burst.
    run_cmd(0, 0, 1, 1, 3, 0, 0, 0, 0, 1);
    run_cmd(0, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    run_cmd(0, 0, 1, 0, 2, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      lr = ($urandom_range(0, 5) == 0);
      ld = 1'($urandom);
      lw = 1'($urandom);
      if (!lr && !ld && !lw) lw = 1'b1;
      run_cmd(lr, ld, lw, $urandom_range(0, 3), $urandom_range(1, 5),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 0);
      if ($urandom_range(0, 9) == 0)
        idle($urandom_range(1, 3), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    idle(4, 0, 0);
    chk("cmd_queue_drained", exp_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
